// File: rtl/pe_pkg.sv
// Shared FSM state type and index-width helper for the pe_iter bit iterator.
package pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // A 1-bit index is still needed when WIDTH is 2 (or degenerate).
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_n.sv
// Combinational priority encoder: idx is the highest set bit of vec, 0 when vec is empty.
module pe_n
    import pe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last hit wins, so the highest index has priority.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/pe_iter.sv
// Accepts a request vector and emits the index of every set bit, highest first, one beat per
// handshake. Define PE_ITER_CNT_EN to add the hit_cnt popcount output.
module pe_iter
    import pe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none
`ifdef PE_ITER_CNT_EN
    ,
    output logic [IDX_W:0]   hit_cnt
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_vec_q, rem_vec_d;
    logic             none_q, none_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             single;

    pe_n #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_pe_n (
        .vec(rem_vec_q),
        .idx(enc_idx),
        .any(enc_any)
    );

    // Removing the lowest set bit leaves zero exactly when one bit remains.
    assign single = enc_any && ((rem_vec_q & (rem_vec_q - WIDTH'(1))) == '0);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        rem_vec_d = rem_vec_q;
        none_d    = none_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        out_idx   = enc_idx;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_vec_d = in_vec;
                    none_d    = ~|in_vec;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_none  = none_q;
                out_last  = none_q | single;
                if (out_ready) begin
                    rem_vec_d = rem_vec_q & ~(WIDTH'(1) << enc_idx);
                    if (out_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_vec_q <= '0;
            none_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_vec_q <= rem_vec_d;
            none_q    <= none_d;
        end
    end

`ifdef PE_ITER_CNT_EN
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // Loaded only at acceptance, so the count is frozen for the whole emit phase.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (state_q == IDLE && in_valid) begin
            hit_cnt_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                hit_cnt_d = hit_cnt_d + CNT_W'(in_vec[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) hit_cnt_q <= '0;
        else     hit_cnt_q <= hit_cnt_d;
    end

    assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_pe_iter.sv
// Scoreboard bench for pe_iter: directed vectors push hand-computed beats, monitors pop and compare.
module tb_pe_iter;

    typedef struct {
        int idx;
        bit last;
        bit none;
        int cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_vec = '0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_none;
    bit         toggle_ready = 1'b0;

    logic        w_valid = 1'b0;
    logic [1:0]  v2 = '0;
    logic [63:0] v64 = '0;
    logic        r2, ov2, lst2, non2;
    logic [0:0]  idx2;
    logic        r64, ov64, lst64, non64;
    logic [5:0]  idx64;

`ifdef PE_ITER_CNT_EN
    logic [3:0] hit_cnt;
    logic [1:0] cnt2;
    logic [6:0] cnt64;
`endif

    exp_t sb[$];
    int   q2[$];
    int   q64[$];
    int   checks = 0;
    int   failures = 0;

    pe_iter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .out_none(out_none)
`ifdef PE_ITER_CNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    pe_iter #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .in_valid(w_valid), .in_ready(r2), .in_vec(v2),
        .out_valid(ov2), .out_ready(1'b1),
        .out_idx(idx2), .out_last(lst2), .out_none(non2)
`ifdef PE_ITER_CNT_EN
        , .hit_cnt(cnt2)
`endif
    );

    pe_iter #(.WIDTH(64)) dut_w64 (
        .clk(clk), .rst(rst),
        .in_valid(w_valid), .in_ready(r64), .in_vec(v64),
        .out_valid(ov64), .out_ready(1'b1),
        .out_idx(idx64), .out_last(lst64), .out_none(non64)
`ifdef PE_ITER_CNT_EN
        , .hit_cnt(cnt64)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d", name, act, act, exp);
        end
    endtask

    function automatic void expect_beat(input int idx, input bit last, input bit none, input int cnt);
        exp_t e;
        e.idx  = idx;
        e.last = last;
        e.none = none;
        e.cnt  = cnt;
        sb.push_back(e);
    endfunction

    // Main monitor: every presented beat is checked against the queue head; stalled beats
    // are checked again without popping, which also proves they hold stable.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got idx %0d last %0b, none expected", out_idx, out_last);
            end else begin
                check("beat_idx", 64'(out_idx), 64'(sb[0].idx));
                check("beat_last", 64'(out_last), 64'(sb[0].last));
                check("beat_none", 64'(out_none), 64'(sb[0].none));
`ifdef PE_ITER_CNT_EN
                check("beat_hit_cnt", 64'(hit_cnt), 64'(sb[0].cnt));
`endif
                if (out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ov2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w2_unexpected_beat: got idx %0d", idx2);
            end else begin
                check("w2_idx", 64'(idx2), 64'(q2[0]));
                check("w2_last", 64'(lst2), 64'd1);
                check("w2_none", 64'(non2), 64'd0);
                void'(q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ov64 === 1'b1) begin
            if (q64.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL w64_unexpected_beat: got idx %0d", idx64);
            end else begin
                check("w64_idx", 64'(idx64), 64'(q64[0]));
                check("w64_last", 64'(lst64), 64'd1);
                check("w64_none", 64'(non64), 64'd0);
                void'(q64.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = toggle_ready ? ~out_ready : 1'b1;
        end
    end

    task automatic send(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || in_ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_none", 64'(out_none), 64'd0);
`ifdef PE_ITER_CNT_EN
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
`endif
        rst = 1'b0;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // 1010_0100: idx 7, 5, 2; first beat next cycle, in_ready back 4 cycles after acceptance.
        expect_beat(7, 1'b0, 1'b0, 3);
        expect_beat(5, 1'b0, 1'b0, 3);
        expect_beat(2, 1'b1, 1'b0, 3);
        send(8'b1010_0100);
        check("first_beat_latency", 64'(out_valid), 64'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("busy_before_n_plus_1", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_n_plus_1", 64'(in_ready), 64'd1);
        drain();

        // All-zero vector, then single LSB and single MSB vectors.
        expect_beat(0, 1'b1, 1'b1, 0);
        send(8'h00);
        drain();
        expect_beat(0, 1'b1, 1'b0, 1);
        send(8'h01);
        drain();
        expect_beat(7, 1'b1, 1'b0, 1);
        send(8'h80);
        drain();

        // 0xFF with out_ready toggling: 7..0 in order, stalled beats rechecked against the head.
        for (int i = 7; i >= 0; i--) expect_beat(i, (i == 0), 1'b0, 8);
        toggle_ready = 1'b1;
        send(8'hFF);
        drain();
        toggle_ready = 1'b0;
        @(posedge clk);
        #2;

        // 0x81 with reset after the idx 7 beat: the idx 0 beat must never appear.
        expect_beat(7, 1'b0, 1'b0, 2);
        send(8'h81);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_idx", 64'(out_idx), 64'd0);
        check("abort_out_last", 64'(out_last), 64'd0);
`ifdef PE_ITER_CNT_EN
        check("abort_hit_cnt", 64'(hit_cnt), 64'd0);
`endif
        check("abort_sb_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_still_idle", 64'(in_ready), 64'd1);

        // in_valid held through EMIT: 0x90 gives 7, 4; then 0x01 gives 0.
        expect_beat(7, 1'b0, 1'b0, 2);
        expect_beat(4, 1'b1, 1'b0, 2);
        expect_beat(0, 1'b1, 1'b0, 1);
        @(negedge clk);
        check("hold_first_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_vec   = 8'h90;
        @(posedge clk);
        #1;
        in_vec = 8'h01;
        check("hold_busy_ignores_valid", 64'(in_ready), 64'd0);
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_second_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // WIDTH=2 and WIDTH=64: MSB then LSB, each a single last beat.
        q2.push_back(1);
        q64.push_back(63);
        @(negedge clk);
        check("w2_ready_a", 64'(r2), 64'd1);
        check("w64_ready_a", 64'(r64), 64'd1);
        w_valid = 1'b1;
        v2      = 2'b10;
        v64     = 64'h8000_0000_0000_0000;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        repeat (3) @(posedge clk);
        q2.push_back(0);
        q64.push_back(0);
        @(negedge clk);
        check("w2_ready_b", 64'(r2), 64'd1);
        check("w64_ready_b", 64'(r64), 64'd1);
        w_valid = 1'b1;
        v2      = 2'b01;
        v64     = 64'h1;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("w2_q_empty", 64'(q2.size()), 64'd0);
        check("w64_q_empty", 64'(q64.size()), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_iter.md
PE_ITER -- requirements
Module: pe_iter

Interface
REQ-001 Parameter: WIDTH, default 8, request vector width; legal range 2..64.
REQ-002 Parameter: IDX_W, default $clog2(WIDTH), index width; derived, never overridden.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  request vector offered.
REQ-006 Port: in_ready  output  1  block accepts a vector.
REQ-007 Port: in_vec  input  WIDTH  request vector; bit WIDTH-1 has highest priority.
REQ-008 Port: out_valid  output  1  index beat valid.
REQ-009 Port: out_ready  input  1  downstream accepts the beat.
REQ-010 Port: out_idx  output  IDX_W  index of the highest remaining set bit.
REQ-011 Port: out_last  output  1  final beat for the current vector.
REQ-012 Port: out_none  output  1  accepted vector was all zero.

Function
REQ-013 The block SHALL be a two-state FSM, IDLE and EMIT, that emits every set bit of each accepted vector, highest index first, one beat per handshake.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid&in_ready SHALL capture in_vec into rem_vec and move to EMIT.
REQ-015 EMIT: in_ready=0, out_valid=1; in_valid SHALL be ignored.
REQ-016 Latency: the first beat SHALL be valid in the cycle after acceptance.
REQ-017 out_idx SHALL be the highest set bit of rem_vec.
REQ-018 out_last SHALL be 1 when rem_vec has exactly one set bit.
REQ-019 On out_valid&out_ready, the block SHALL clear bit out_idx in rem_vec.
REQ-020 If that beat has out_last=1, the FSM SHALL return to IDLE.
REQ-021 Throughput: with out_ready held high, the block SHALL emit one beat per cycle.
REQ-022 An N-bit-set vector SHALL occupy N+1 cycles from acceptance to the next in_ready.
REQ-023 out_valid, out_idx, out_last and out_none SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 An all-zero vector SHALL produce exactly one beat with out_none=1, out_idx=0, out_last=1; the output SHALL never be X.
REQ-025 out_none SHALL be 0 for any vector that has at least one set bit.
REQ-026 Bit WIDTH-1 and bit 0 SHALL encode to WIDTH-1 and 0 respectively, with no wrap-around.

Reset
REQ-027 rst SHALL act at the clock edge and take priority over every handshake.
REQ-028 Reset values SHALL be: FSM=IDLE, rem_vec=0, in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0, hit_cnt=0.
REQ-029 Reset asserted during EMIT SHALL abandon the vector with no further beats.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 When macro PE_ITER_CNT_EN is defined, the block SHALL add port hit_cnt, output, IDX_W+1 bits, holding the number of set bits in the vector being emitted.
REQ-032 hit_cnt SHALL be loaded at acceptance and held constant through EMIT; it SHALL be 0 for an all-zero vector.
REQ-033 When PE_ITER_CNT_EN is undefined, the port and the popcount logic SHALL be absent, with all other behaviour identical.

Structure
REQ-034 Package pe_pkg SHALL hold the FSM state enum (IDLE, EMIT) and the function clog2_min1, which keeps IDX_W at least 1.
REQ-035 Sub-module pe_n SHALL be a combinational parametrised priority encoder (inputs: vec; outputs: idx, any), instantiated once on rem_vec.
REQ-036 Expected implementation size: 120-400 lines of RTL in total.

Verification
REQ-037 WIDTH=8, in_vec=8'b1010_0100, out_ready=1: beats idx 7, 5, 2, with last=1 on idx 2; in_ready returns 4 cycles after acceptance.
REQ-038 in_vec=8'h00: one beat with out_none=1, idx=0, last=1; hit_cnt=0 when PE_ITER_CNT_EN is defined.
REQ-039 in_vec=8'hFF, out_ready toggling 1/0: 8 beats idx 7..0 in order; outputs stable on stalled cycles; hit_cnt=8.
REQ-040 in_vec=8'h81 accepted, rst pulsed after the first beat (idx 7): no idx 0 beat; in_ready=1 after reset.
REQ-041 in_valid held high during EMIT with a second vector 8'h01: second vector accepted only after the first vector's last beat; then idx 0 with last=1.
REQ-042 WIDTH=2 and WIDTH=64, single bit set at the MSB and then at the LSB: idx WIDTH-1 and then 0, each with last=1.
